// File: rtl/i2s_dac_serializer.sv
//------------------------------------------------------------------------------
// Module      : i2s_dac_serializer
// Description : I2S transmit serializer for the codec DAC path. Accepts
//               stereo PCM pairs through a one-entry holding register and
//               shifts them out MSB first on dacdat. bclk and daclrc come
//               from the codec (slave mode) and are oversampled on mclk.
//               Optional macro I2S_DAC_UNDERRUN_MUTE_EN: when defined, an
//               underrun clears the active pair so a silent frame is sent;
//               when undefined, the previous pair is repeated.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module i2s_dac_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  bclk,
  input  logic                  daclrc,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  dacdat,
  output logic                  underrun
);

  // Counter must be able to hold DATA_WIDTH, which marks "word exhausted".
  localparam int                C_CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_DONE = C_CNT_W'(DATA_WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  // Synchronizer chains and edge-history flops
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrc_sync_q,  lrc_sync_d;
  logic                   bclk_hist_q, bclk_hist_d;
  logic                   lrc_hist_q,  lrc_hist_d;

  // Input holding register
  logic [DATA_WIDTH-1:0]  hold_left_q,  hold_left_d;
  logic [DATA_WIDTH-1:0]  hold_right_q, hold_right_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   in_ready_q,   in_ready_d;

  // Active pair and serializer
  logic [DATA_WIDTH-1:0]  act_left_q,   act_left_d;
  logic [DATA_WIDTH-1:0]  act_right_q,  act_right_d;
  logic [DATA_WIDTH-1:0]  shift_q,      shift_d;
  logic [C_CNT_W-1:0]     cnt_q,        cnt_d;
  logic                   aligned_q,    aligned_d;
  logic                   dacdat_q,     dacdat_d;
  logic                   underrun_q,   underrun_d;

  // Synchronized levels and their detected edges
  logic                   bclk_s;
  logic                   lrc_s;
  logic                   bclk_fall;
  logic                   lrc_fall;
  logic                   lrc_rise;
  logic                   accept;

  // Edge detection: compare the last sync stage against its history flop.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
    lrc_sync_d  = {lrc_sync_q[SYNC_STAGES-2:0], daclrc};
    bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    lrc_s       = lrc_sync_q[SYNC_STAGES-1];
    bclk_hist_d = bclk_s;
    lrc_hist_d  = lrc_s;
    bclk_fall   = bclk_hist_q & ~bclk_s;
    lrc_fall    = lrc_hist_q  & ~lrc_s;
    lrc_rise    = ~lrc_hist_q & lrc_s;
  end

  // Next-state logic for the holding register, frame start and serializer.
  always_comb begin
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    hold_valid_d = hold_valid_q;
    act_left_d   = act_left_q;
    act_right_d  = act_right_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    aligned_d    = aligned_q;
    dacdat_d     = dacdat_q;
    underrun_d   = 1'b0;

    // An accept can only happen while the holding register is empty, so it
    // never collides with the frame-start transfer below.
    accept = in_valid & in_ready_q;
    if (accept) begin
      hold_left_d  = in_left;
      hold_right_d = in_right;
      hold_valid_d = 1'b1;
    end

    if (lrc_fall) begin
      // Frame start: the first falling edge after reset also aligns us.
      aligned_d = 1'b1;
      cnt_d     = '0;
      if (hold_valid_q) begin
        act_left_d   = hold_left_q;
        act_right_d  = hold_right_q;
        shift_d      = hold_left_q;
        hold_valid_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_DAC_UNDERRUN_MUTE_EN
        act_left_d  = '0;
        act_right_d = '0;
        shift_d     = '0;
`else
        shift_d     = act_left_q;
`endif
      end
    end else if (lrc_rise && aligned_q) begin
      // Right channel load; dacdat keeps its value, giving the 1-bclk delay.
      shift_d = act_right_q;
      cnt_d   = '0;
    end else if (bclk_fall) begin
      if (cnt_q < C_CNT_DONE) begin
        dacdat_d = shift_q[DATA_WIDTH-1];
        shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + C_CNT_ONE;
      end else begin
        // Slots beyond the word (or before alignment) carry zero.
        dacdat_d = 1'b0;
      end
    end

    in_ready_d = ~hold_valid_d;
  end

  // State registers; reset asserts asynchronously and releases on mclk.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      bclk_sync_q  <= '0;
      lrc_sync_q   <= '0;
      bclk_hist_q  <= 1'b0;
      lrc_hist_q   <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      hold_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      act_left_q   <= '0;
      act_right_q  <= '0;
      shift_q      <= '0;
      cnt_q        <= C_CNT_DONE;
      aligned_q    <= 1'b0;
      dacdat_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrc_sync_q   <= lrc_sync_d;
      bclk_hist_q  <= bclk_hist_d;
      lrc_hist_q   <= lrc_hist_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      hold_valid_q <= hold_valid_d;
      in_ready_q   <= in_ready_d;
      act_left_q   <= act_left_d;
      act_right_q  <= act_right_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      aligned_q    <= aligned_d;
      dacdat_q     <= dacdat_d;
      underrun_q   <= underrun_d;
    end
  end

  assign in_ready = in_ready_q;
  assign dacdat   = dacdat_q;
  assign underrun = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_dac_serializer.sv
//------------------------------------------------------------------------------
// Module      : tb_i2s_dac_serializer
// Description : Directed self-checking bench for i2s_dac_serializer. Acts as
//               the codec (bclk = mclk/8, 64 bclk per frame) and records
//               dacdat per bclk slot, SYNC_STAGES+1 mclk after each fall.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_dac_serializer;

  localparam int DW = 16;

  logic          mclk     = 1'b0;
  logic          rst      = 1'b0;
  logic          bclk     = 1'b1;
  logic          daclrc   = 1'b1;
  logic [DW-1:0] in_left  = '0;
  logic [DW-1:0] in_right = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          dacdat;
  logic          underrun;

  int n_tests  = 0;
  int n_fail   = 0;
  int ur_cnt   = 0;
  int cur_slot = 0;
  int acc_cnt  = 0;
  int u0;

  logic rx_bit  [0:63];
  logic pre_bit [0:63];
  logic ir_pre, ir_at, ur_pre, ur_at;

  logic [15:0] tbl_l [0:10];
  logic [15:0] tbl_r [0:10];
  logic [15:0] got_l [0:9];
  logic [15:0] got_r [0:9];
  logic [1:0]  rdy   [0:9];

  i2s_dac_serializer #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .mclk     (mclk),
    .rst      (rst),
    .bclk     (bclk),
    .daclrc   (daclrc),
    .in_left  (in_left),
    .in_right (in_right),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dacdat   (dacdat),
    .underrun (underrun)
  );

  // ~12.5 MHz system clock
  always #40 mclk = ~mclk;

  // Count mclk cycles with underrun high
  always @(negedge mclk) if (underrun) ur_cnt <= ur_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input int start, input int n);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = {w[14:0], rx_bit[start+i]};
    return w;
  endfunction

  function automatic int ones_in(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (rx_bit[i] !== 1'b0) c++;
    return c;
  endfunction

  // One codec frame: daclrc low for left_len slots, then high; bclk 4/4 mclk.
  task automatic codec_frame(input int left_len, input int total);
    for (int s = 0; s < total; s++) begin
      cur_slot = s;
      @(negedge mclk); bclk = 1'b0; daclrc = (s >= left_len);
      @(negedge mclk);
      @(negedge mclk);
      pre_bit[s] = dacdat;
      if (s == 0) begin ir_pre = in_ready; ur_pre = underrun; end
      @(negedge mclk);
      rx_bit[s] = dacdat;
      if (s == 0) begin ir_at = in_ready; ur_at = underrun; end
      @(negedge mclk); bclk = 1'b1;
      repeat (3) @(negedge mclk);
    end
  endtask

  // Offer one pair and wait (bounded) for it to be accepted.
  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int g;
    g = 0;
    @(negedge mclk);
    while (!in_ready && g < 4000) begin @(negedge mclk); g++; end
    check_eq("push_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_left = l; in_right = r;
    @(negedge mclk);
    in_valid = 1'b0;
  endtask

  // Keep in_valid high, presenting the next table entry after each accept.
  task automatic feed(input int n);
    int k, g;
    k = 0; g = 0;
    @(negedge mclk);
    while (k < n && g < 6000) begin
      in_valid = 1'b1; in_left = tbl_l[k]; in_right = tbl_r[k];
      if (in_ready) begin k++; acc_cnt++; end
      @(negedge mclk); g++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
    check_eq({tag, "_left"},   32'(word_at(1, 16)),  32'(el));
    check_eq({tag, "_ltrail"}, 32'(ones_in(17, 31)), 32'd0);
    check_eq({tag, "_right"},  32'(word_at(33, 16)), 32'(er));
    check_eq({tag, "_rtrail"}, 32'(ones_in(49, 63)), 32'd0);
  endtask

  initial begin
    #(25000 * 80);
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl_l[0] = 16'h0001; tbl_r[0] = 16'h8000;
    tbl_l[1] = 16'hFFFF; tbl_r[1] = 16'h0000;
    tbl_l[2] = 16'h7FFF; tbl_r[2] = 16'h8001;
    tbl_l[3] = 16'h1357; tbl_r[3] = 16'h2468;
    tbl_l[4] = 16'hDEAD; tbl_r[4] = 16'hBEEF;
    tbl_l[5] = 16'h5555; tbl_r[5] = 16'hAAAA;
    tbl_l[6] = 16'h0F0F; tbl_r[6] = 16'hF0F0;
    tbl_l[7] = 16'hC001; tbl_r[7] = 16'h3FFE;
    tbl_l[8] = 16'h4321; tbl_r[8] = 16'h8765;
    tbl_l[9] = 16'h00FF; tbl_r[9] = 16'hFF00;
    tbl_l[10] = 16'h1234; tbl_r[10] = 16'h8001;

    // Reset values
    rst = 1'b0;
    repeat (4) @(negedge mclk);
    check_eq("rst_dacdat",   32'(dacdat),   32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    repeat (8) @(negedge mclk);

    // Basic pair
    push(16'hA5C3, 16'h0F0F);
    u0 = ur_cnt;
    codec_frame(32, 64);
    check_eq("basic_slot0", 32'(rx_bit[0]), 32'd0);
    check_eq("basic_latency", 32'({pre_bit[1], rx_bit[1]}), 32'b01);
    check_frame("basic", 16'hA5C3, 16'h0F0F);
    check_eq("basic_rdy", 32'({ir_pre, ir_at}), 32'b01);
    check_eq("basic_ur", 32'(ur_cnt - u0), 32'd0);

    // Continuous handshake over 10 frames
    u0 = ur_cnt; acc_cnt = 0;
    fork
      begin
        for (int f = 0; f < 10; f++) begin
          codec_frame(32, 64);
          got_l[f] = word_at(1, 16);
          got_r[f] = word_at(33, 16);
          rdy[f]   = {ir_pre, ir_at};
        end
      end
      feed(11);
    join
    for (int f = 0; f < 10; f++) begin
      check_eq($sformatf("hs_left%0d", f),  32'(got_l[f]), 32'(tbl_l[f]));
      check_eq($sformatf("hs_right%0d", f), 32'(got_r[f]), 32'(tbl_r[f]));
      check_eq($sformatf("hs_rdy%0d", f),   32'(rdy[f]),   32'b01);
    end
    check_eq("hs_accepts", 32'(acc_cnt), 32'd11);
    check_eq("hs_ur", 32'(ur_cnt - u0), 32'd0);

    // Underrun: 1234/8001 is held, nothing follows it
    u0 = ur_cnt;
    codec_frame(32, 64);
    check_frame("ur_a", 16'h1234, 16'h8001);
    check_eq("ur_a_cnt", 32'(ur_cnt - u0), 32'd0);
    u0 = ur_cnt;
    codec_frame(32, 64);
    check_eq("ur_b_cnt", 32'(ur_cnt - u0), 32'd1);
    check_eq("ur_b_pulse", 32'({ur_pre, ur_at}), 32'b01);
`ifdef I2S_DAC_UNDERRUN_MUTE_EN
    check_frame("ur_b", 16'h0000, 16'h0000);
`else
    check_frame("ur_b", 16'h1234, 16'h8001);
`endif

    // Short left half (8 data bits), long right half
    u0 = ur_cnt;
    push(16'hB7E1, 16'h96AD);
    codec_frame(9, 64);
    check_eq("short_left", 32'(word_at(1, 8)), 32'h00B7);
    check_eq("short_hold", 32'(rx_bit[9]), 32'd1);
    check_eq("short_right", 32'(word_at(10, 16)), 32'h96AD);
    check_eq("short_trail", 32'(ones_in(26, 63)), 32'd0);
    check_eq("short_ur", 32'(ur_cnt - u0), 32'd0);

    // Reset mid-word during the right half, then re-alignment
    push(16'hFFFF, 16'hFFFF);
    fork
      codec_frame(32, 64);
      begin
        wait (cur_slot == 2);
        push(16'h7E81, 16'h0118);
        wait (cur_slot == 36);
        repeat (3) @(negedge mclk);
        check_eq("rmid_pre_dacdat", 32'(dacdat),   32'd1);
        check_eq("rmid_pre_ready",  32'(in_ready), 32'd0);
        #5 rst = 1'b0;
        #1;
        check_eq("rmid_dacdat", 32'(dacdat),   32'd0);
        check_eq("rmid_ready",  32'(in_ready), 32'd1);
        repeat (6) @(negedge mclk);
        rst = 1'b1;
        push(16'h5A5A, 16'hC3A5);
      end
    join
    check_eq("rmid_left", 32'(word_at(1, 16)), 32'hFFFF);
    check_eq("rmid_quiet", 32'(ones_in(36, 63)), 32'd0);
    u0 = ur_cnt;
    codec_frame(32, 64);
    check_eq("align_slot0", 32'(rx_bit[0]), 32'd0);
    check_frame("align", 16'h5A5A, 16'hC3A5);
    check_eq("align_ur", 32'(ur_cnt - u0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
